// File: rtl/datapath_pkg.sv
// -----------------------------------------------------------------------------
// datapath_pkg
//
// Purpose : Shared constants and FSM state encoding for the register-bank
//           dump engine (regbank_dump).
//
// Contents:
//   DW_DEFAULT   - default data word width in bits
//   AW_DEFAULT   - default address width (bank depth is 2**AW words)
//   dump_state_e - dump FSM state encoding
// -----------------------------------------------------------------------------
package datapath_pkg;

    localparam int DW_DEFAULT = 32;
    localparam int AW_DEFAULT = 5;

    // Dump FSM states.
    //   ST_IDLE : waiting for start
    //   ST_REQ  : one-cycle read strobe to the bank at cur_addr
    //   ST_CAPT : bank data is valid this cycle; capture it into the output regs
    //   ST_HOLD : word presented on the output, waiting for out_ready
    //   ST_FIN  : one-cycle done pulse after the final word was accepted
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_CAPT = 3'd2,
        ST_HOLD = 3'd3,
        ST_FIN  = 3'd4
    } dump_state_e;

endpackage : datapath_pkg

// File: rtl/regbank_dump.sv
// -----------------------------------------------------------------------------
// regbank_dump
//
// Purpose : Reads a contiguous (wrapping) address range out of a register bank
//           with one-cycle read latency and streams each word out through a
//           valid/ready output port, tagging each word with its bank address
//           and flagging the final word of the range.
//
// Parameters:
//   DW - data word width in bits
//   AW - address width; bank depth is 2**AW words
//
// Ports:
//   clk        in   clock, all state updates on the rising edge
//   rst_n      in   asynchronous active-low reset
//   start      in   single-cycle dump request, honoured only in IDLE
//   first_addr in   first address of the dump (sampled with start)
//   last_addr  in   last address of the dump (sampled with start)
//   rd_en      out  bank read strobe, high only in REQ
//   rd_addr    out  bank read address, always equal to the current address
//   rd_data    in   bank read data, valid one cycle after rd_en
//   out_valid  out  out_data / out_addr / out_last hold a word
//   out_ready  in   consumer accepts the word
//   out_data   out  dumped word
//   out_addr   out  bank address of out_data
//   out_last   out  out_data is the final word of the dump
//   busy       out  high in every state except IDLE
//   done       out  one-cycle pulse after the final word is accepted
//
// Output handshake: a word transfers on a rising clock edge where out_valid
// and out_ready are both high. Once out_valid is raised, out_data, out_addr and
// out_last stay constant and out_valid stays high until that transfer edge;
// out_valid is never withdrawn without a transfer (except by reset).
// -----------------------------------------------------------------------------
module regbank_dump
    import datapath_pkg::*;
#(
    parameter int DW = DW_DEFAULT,
    parameter int AW = AW_DEFAULT
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [AW-1:0] first_addr,
    input  logic [AW-1:0] last_addr,
    output logic          rd_en,
    output logic [AW-1:0] rd_addr,
    input  logic [DW-1:0] rd_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic [AW-1:0] out_addr,
    output logic          out_last,
    output logic          busy,
    output logic          done
);

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    dump_state_e   state_q,     state_d;
    logic [AW-1:0] cur_addr_q,  cur_addr_d;
    logic [AW-1:0] end_addr_q,  end_addr_d;
    logic [DW-1:0] out_data_q,  out_data_d;
    logic [AW-1:0] out_addr_q,  out_addr_d;
    logic          out_last_q,  out_last_d;
    logic          out_valid_q, out_valid_d;

    // A word is handed to the consumer in this cycle.
    logic          xfer;

    assign xfer = (state_q == ST_HOLD) && out_valid_q && out_ready;

    // -------------------------------------------------------------------------
    // Next-state and datapath logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        cur_addr_d  = cur_addr_q;
        end_addr_d  = end_addr_q;
        out_data_d  = out_data_q;
        out_addr_d  = out_addr_q;
        out_last_d  = out_last_q;
        out_valid_d = out_valid_q;

        unique case (state_q)
            ST_IDLE: begin
                // The range is latched only here, so start pulses seen in any
                // other state cannot disturb a dump in progress.
                if (start) begin
                    cur_addr_d = first_addr;
                    end_addr_d = last_addr;
                    state_d    = ST_REQ;
                end
            end

            ST_REQ: begin
                // rd_en is decoded from this state; the bank answers next cycle.
                state_d = ST_CAPT;
            end

            ST_CAPT: begin
                out_data_d  = rd_data;
                out_addr_d  = cur_addr_q;
                // Equality against the latched end address terminates the
                // dump; with natural AW-bit wrap this covers first > last
                // (wrap through 2**AW-1 -> 0) and first == last (one word).
                out_last_d  = (cur_addr_q == end_addr_q);
                out_valid_d = 1'b1;
                state_d     = ST_HOLD;
            end

            ST_HOLD: begin
                if (xfer) begin
                    out_valid_d = 1'b0;
                    if (out_last_q) begin
                        state_d = ST_FIN;
                    end else begin
                        // Natural modulo-2**AW wrap of the address counter.
                        cur_addr_d = cur_addr_q + AW'(1);
                        state_d    = ST_REQ;
                    end
                end
            end

            ST_FIN: begin
                // start is deliberately not looked at here; it is honoured
                // again from the IDLE cycle that follows.
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cur_addr_q  <= '0;
            end_addr_q  <= '0;
            out_data_q  <= '0;
            out_addr_q  <= '0;
            out_last_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_addr_q  <= cur_addr_d;
            end_addr_q  <= end_addr_d;
            out_data_q  <= out_data_d;
            out_addr_q  <= out_addr_d;
            out_last_q  <= out_last_d;
            out_valid_q <= out_valid_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    // Strobes and status are pure decodes of the state register, so they drop
    // together with the state when reset is asserted asynchronously.
    assign rd_en     = (state_q == ST_REQ);
    assign rd_addr   = cur_addr_q;
    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_FIN);

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_addr  = out_addr_q;
    assign out_last  = out_last_q;

endmodule : regbank_dump

// File: tb/tb_regbank_dump.sv
// -----------------------------------------------------------------------------
// tb_regbank_dump
//
// Bench for regbank_dump (DW=32, AW=5). A behavioural bank model answers read
// strobes one cycle later; a range reference model queues the expected
// {data, addr, last} words when a dump is started, and a negedge monitor pops
// and compares whenever a word is accepted on the output.
// -----------------------------------------------------------------------------
module tb_regbank_dump;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int DEPTH = 1 << AW;
    localparam int EW    = DW + AW + 1;

    // -------------------------------------------------------------------------
    // Clock / reset / DUT
    // -------------------------------------------------------------------------
    logic          clk;
    logic          rst_n;
    logic          start;
    logic [AW-1:0] first_addr;
    logic [AW-1:0] last_addr;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [AW-1:0] out_addr;
    logic          out_last;
    logic          busy;
    logic          done;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    regbank_dump #(.DW(DW), .AW(AW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .first_addr (first_addr),
        .last_addr  (last_addr),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_addr   (out_addr),
        .out_last   (out_last),
        .busy       (busy),
        .done       (done)
    );

    // Bank model: one-cycle read latency.
    logic [DW-1:0] mem [DEPTH];
    always @(posedge clk) begin
        if (rd_en) rd_data <= mem[rd_addr];
    end

    // -------------------------------------------------------------------------
    // Scoreboard state
    // -------------------------------------------------------------------------
    logic [EW-1:0] exp_q[$];
    int n_checks  = 0;
    int n_fail    = 0;
    int rd_cnt    = 0;
    int done_cnt  = 0;
    int pop_cnt   = 0;
    int ready_mode = 0;   // 0: fixed by driver, 1: random each cycle

    task automatic check_eq(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the dump walks upward from first, wrapping modulo the
    // bank depth, and stops after emitting last.
    task automatic push_dump(input int f, input int l, output int n);
        int a;
        logic [EW-1:0] e;
        a = f;
        n = 0;
        while (1) begin
            e = {mem[a], AW'(a), (a == l) ? 1'b1 : 1'b0};
            exp_q.push_back(e);
            n++;
            if (a == l) break;
            a = (a + 1) % DEPTH;
        end
    endtask

    // Random back-pressure.
    always begin
        @(posedge clk);
        #1;
        if (ready_mode == 1) out_ready = 1'($urandom_range(0, 1));
    end

    // -------------------------------------------------------------------------
    // Monitor
    // -------------------------------------------------------------------------
    logic          pend_done = 1'b0;
    logic          hold_seen = 1'b0;
    logic [DW-1:0] hold_data;
    logic [AW-1:0] hold_addr;
    logic          hold_last;

    always @(negedge clk) begin
        logic [EW-1:0] e;
        if (!rst_n) begin
            pend_done = 1'b0;
            hold_seen = 1'b0;
        end else begin
            if (done) done_cnt++;
            check_eq("done_pulse", 64'(done), 64'(pend_done));
            if (rd_en) rd_cnt++;
            if (out_valid) check_eq("rd_en_while_valid", 64'(rd_en), 64'd0);
            if (hold_seen && out_valid) begin
                check_eq("hold_data_stable", 64'(out_data), 64'(hold_data));
                check_eq("hold_addr_stable", 64'(out_addr), 64'(hold_addr));
                check_eq("hold_last_stable", 64'(out_last), 64'(hold_last));
            end
            if (out_valid && out_ready) begin
                pop_cnt++;
                if (exp_q.size() == 0) begin
                    check_eq("unexpected_word", 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check_eq("out_data", 64'(out_data), 64'(e[EW-1:AW+1]));
                    check_eq("out_addr", 64'(out_addr), 64'(e[AW:1]));
                    check_eq("out_last", 64'(out_last), 64'(e[0]));
                end
                pend_done = out_last;
                hold_seen = 1'b0;
            end else if (out_valid) begin
                hold_seen = 1'b1;
                hold_data = out_data;
                hold_addr = out_addr;
                hold_last = out_last;
                pend_done = 1'b0;
            end else begin
                hold_seen = 1'b0;
                pend_done = 1'b0;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Driver tasks
    // -------------------------------------------------------------------------
    // Issue a dump, check first-word latency, wait for done, then check read
    // strobe count, done count and that every expected word was consumed.
    task automatic run_dump(input int f, input int l, input bit fin_probe);
        int n, rs, ds, t;
        push_dump(f, l, n);
        rs = rd_cnt;
        ds = done_cnt;
        first_addr = AW'(f);
        last_addr  = AW'(l);
        start      = 1'b1;
        @(posedge clk);
        #1;
        start      = 1'b0;
        first_addr = AW'($urandom_range(0, DEPTH - 1));
        last_addr  = AW'($urandom_range(0, DEPTH - 1));
        t = 0;
        while (!out_valid && t < 10) begin
            @(posedge clk);
            #1;
            t++;
        end
        check_eq("first_valid_latency", 64'(t), 64'd2);
        t = 0;
        while (!done && t < 64 * n + 50) begin
            @(posedge clk);
            #1;
            t++;
        end
        check_eq("done_seen", 64'(done), 64'd1);
        if (fin_probe) start = 1'b1;
        @(posedge clk);
        #1;
        if (fin_probe) begin
            start = 1'b0;
            check_eq("fin_start_ignored", 64'(busy), 64'd0);
        end
        check_eq("rd_en_count", 64'(rd_cnt - rs), 64'(n));
        check_eq("done_count", 64'(done_cnt - ds), 64'd1);
        check_eq("queue_drained", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic wait_valid(input string name);
        int t;
        t = 0;
        while (!out_valid && t < 20) begin
            @(posedge clk);
            #1;
            t++;
        end
        check_eq(name, 64'(out_valid), 64'd1);
    endtask

    // -------------------------------------------------------------------------
    // Watchdog
    // -------------------------------------------------------------------------
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // -------------------------------------------------------------------------
    // Stimulus
    // -------------------------------------------------------------------------
    initial begin
        int n, base, t, rs, ds;

        rst_n      = 1'b0;
        start      = 1'b0;
        first_addr = '0;
        last_addr  = '0;
        out_ready  = 1'b1;
        rd_data    = '0;
        for (int i = 0; i < DEPTH; i++) mem[i] = DW'(i * 3);

        // Reset values.
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_rd_en",     64'(rd_en),     64'd0);
        check_eq("rst_out_valid", 64'(out_valid), 64'd0);
        check_eq("rst_out_last",  64'(out_last),  64'd0);
        check_eq("rst_busy",      64'(busy),      64'd0);
        check_eq("rst_done",      64'(done),      64'd0);
        check_eq("rst_rd_addr",   64'(rd_addr),   64'd0);
        check_eq("rst_out_data",  64'(out_data),  64'd0);
        check_eq("rst_out_addr",  64'(out_addr),  64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic 0..3 with MEM[i]=i*3.
        run_dump(0, 3, 1'b0);
        // Wrapping range.
        run_dump(30, 1, 1'b0);
        // Single word, with a start pulse in the FIN cycle, then an immediate
        // start in the following IDLE cycle.
        run_dump(7, 7, 1'b1);
        run_dump(5, 6, 1'b0);

        // Back-pressure: out_ready low for 5 cycles in HOLD.
        out_ready = 1'b0;
        fork
            run_dump(4, 6, 1'b0);
            begin
                wait_valid("stall_reach_hold");
                rs = rd_cnt;
                repeat (5) begin
                    @(posedge clk);
                    #1;
                    check_eq("stall_valid_held", 64'(out_valid), 64'd1);
                end
                @(negedge clk);
                check_eq("stall_no_rd_en", 64'(rd_cnt - rs), 64'd0);
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join

        // start pulsed in HOLD with a different range must be ignored.
        out_ready = 1'b0;
        fork
            run_dump(10, 13, 1'b0);
            begin
                wait_valid("busy_start_reach_hold");
                first_addr = AW'(20);
                last_addr  = AW'(25);
                start      = 1'b1;
                @(posedge clk);
                #1;
                start = 1'b0;
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join

        // Full bank.
        run_dump(0, DEPTH - 1, 1'b0);

        // Reset in the middle of a full-bank dump.
        base = pop_cnt;
        push_dump(0, DEPTH - 1, n);
        first_addr = '0;
        last_addr  = AW'(DEPTH - 1);
        start      = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        t = 0;
        while (pop_cnt < base + 2 && t < 200) begin
            @(posedge clk);
            #1;
            t++;
        end
        check_eq("mid_reset_two_words", 64'(pop_cnt - base), 64'd2);
        ds = done_cnt;
        rst_n = 1'b0;
        #1;
        check_eq("mid_reset_out_valid", 64'(out_valid), 64'd0);
        check_eq("mid_reset_busy",      64'(busy),      64'd0);
        check_eq("mid_reset_done",      64'(done),      64'd0);
        check_eq("mid_reset_rd_en",     64'(rd_en),     64'd0);
        exp_q.delete();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_eq("post_reset_idle", 64'(busy), 64'd0);
        check_eq("post_reset_no_done", 64'(done_cnt - ds), 64'd0);
        run_dump(0, 0, 1'b0);

        // Randomized ranges, bank contents and back-pressure.
        ready_mode = 1;
        for (int k = 0; k < 10; k++) begin
            for (int i = 0; i < DEPTH; i++) mem[i] = DW'($urandom);
            run_dump($urandom_range(0, DEPTH - 1), $urandom_range(0, DEPTH - 1),
                     1'($urandom_range(0, 1)));
        end
        ready_mode = 0;
        out_ready  = 1'b1;

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_regbank_dump
